pwm_cbc_modulator: RTL and testbench
====================================

Name: pwm_cbc_modulator

Overview:
- Drive side of the switched-converter plant models: generates the model step strobe `ce` and the switch command `s1`.
- `s1` comes from a counter-based PWM carrier with double-buffered period/duty and a cycle-by-cycle current limit fed back from the model's `iL`.
- Sits between the control/register layer and a plant model (e.g. the buck-boost L2 model), closing the HIL loop.

Parameters:
- MODEL_DATA_WIDTH, 32, width of signed fixed-point `iL`/`ilim` (same Q format as the plant model).
- CNT_WIDTH, 16, width of carrier counter, `period` and `duty`.
- CE_DIV_WIDTH, 8, width of the strobe prescaler.

Ports:
- aclk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- enable  in  1  run control; level-sensitive.
- ce_div  in  CE_DIV_WIDTH  `ce` asserted once every `ce_div`+1 aclk cycles.
- period  in  CNT_WIDTH  carrier terminal count; the PWM period is `period`+1 ce steps.
- duty  in  CNT_WIDTH  number of ce steps per period with `s1`=1.
- iL  in  MODEL_DATA_WIDTH  signed inductor current from the plant.
- ilim  in  MODEL_DATA_WIDTH  signed current limit.
- ce  out  1  model step strobe, registered, 1-cycle pulse.
- s1  out  1  switch command, registered.
- period_start  out  1  registered pulse, coincident with the ce that starts a period.
- trip  out  1  current-limit latch for the current period.
- cnt  out  CNT_WIDTH  carrier count (debug/observability).

Behaviour:
- Reset (resetn=0 at a clock edge): ce=0, s1=0, period_start=0, trip=0, cnt=0, prescaler=0, period_active=0, duty_active=0, first=1.
- Prescaler:
  - When enable=1, div_cnt counts 0..ce_div and then wraps.
  - The ce register is set to 1 for the cycle following div_cnt==ce_div, otherwise 0.
  - ce_div=0 gives ce=1 every cycle.
  - ce_div is sampled live; a change takes effect at the next wrap, or immediately if the new value is below div_cnt.
- Step update: on each clock edge where the ce register is 1 (denote step k):
  - n = 0 if first=1 or cnt==period_active, else cnt+1; cnt<=n.
  - If n==0 (period start):
    - period_active<=period, duty_active<=duty (shadow load);
    - trip cleared; period_start register set so it pulses with the next ce; first<=0.
  - Otherwise, trip <= trip | (s1 & (iL > ilim)), using a signed strict compare on iL as sampled at this edge.
  - s1 <= (n < duty_sel) & ~trip_next, where duty_sel = duty if n==0, else duty_active.
  - Latency: the new s1 is visible the cycle after the ce pulse, stable before the plant's next ce capture.
- Duty bounds:
  - duty=0 gives s1 constantly 0.
  - duty >= period+1 gives s1 constantly 1 (100%), except when trip=1.
  - Comparison is unsigned on CNT_WIDTH.
- Period bounds: period=0 makes every ce a period start; s1 = (duty>0) & ~trip.
- Shadowing: period/duty writes mid-period have no effect until the next period start.
  - Because of the n==0 selection, duty_sel at a period start is the newly sampled `duty`.
- Simultaneous events: a period start and an over-current on the same step resolve as period start (trip cleared, s1 per new duty). The over-current re-trips on the next step if it persists.
- Trip only sets while s1=1. It holds s1=0 until the next period start, then auto-clears.
- Disable: enable=0 at an edge gives, on the next cycle, ce=0, s1=0, period_start=0, trip=0, div_cnt=0, cnt=0, first=1. The shadows retain their values.
  - Re-enable: the first ce after enable rises is a period start (cnt=0, period_start=1).
- Reset mid-operation overrides everything and returns all state to the reset values on the next cycle.
- No combinational path from inputs to outputs.

Test Plan:
- Prescaler: ce_div=3, enable 0->1 → ce high exactly 1 cycle in every 4; ce_div=0 → ce high every cycle; enable=0 → ce stays 0.
- Basic PWM: ce_div=0, period=9, duty=3 → period_start every 10 ce; s1 high for 3 consecutive ce steps (cnt 0..2) and low for 7; cnt wraps 9→0.
- Shadowing: duty 3→7 written while cnt=5 → the remainder of the current period keeps 3; the next period has s1 high for 7 steps; the period 9→4 change takes effect only at the next start.
- Bounds: duty=0 → s1 never 1; period=9, duty=10 → s1 constant 1 with period_start still every 10; period=0, duty=1 → period_start every ce, s1=1.
- Current limit:
  - setup: period=9, duty=6, ilim=0x0100_0000; iL exceeds it at cnt=2 → trip=1 and s1=0 from the next cycle until period_start, where trip clears and s1=1.
  - iL=ilim exactly → no trip.
  - iL negative with ilim positive → no trip.
- Disable/reset: enable dropped at cnt=4 with s1=1 → next cycle s1=0, ce=0, cnt=0; on re-enable the first ce gives period_start=1, cnt=0. resetn pulsed mid-period → all outputs 0 the next cycle.

Source files
------------

// File: rtl/pwm_cbc_modulator.sv
// ---------------------------------------------------------------------------
// pwm_cbc_modulator
//
// Drive side of the switched-converter plant models. Produces the model step
// strobe `ce` from an aclk prescaler, and the switch command `s1` from a
// counter-based PWM carrier. The carrier has double-buffered period/duty and
// a cycle-by-cycle current limit. The limit is fed back from the plant's
// inductor current.
//
// Ports:
//   aclk          clock
//   resetn        synchronous, active-low reset
//   enable        run control (level); low clears the carrier and prescaler
//   ce_div        ce is asserted once every ce_div+1 aclk cycles
//   period        carrier terminal count (PWM period = period+1 ce steps)
//   duty          ce steps per period with s1=1
//   iL            signed inductor current from the plant
//   ilim          signed current limit (same Q format as iL)
//   ce            registered 1-cycle model step strobe
//   s1            registered switch command
//   period_start  registered pulse, high together with the ce that starts a period
//   trip          current-limit latch for the current period
//   cnt           carrier count (observability)
// ---------------------------------------------------------------------------
module pwm_cbc_modulator #(
    parameter int MODEL_DATA_WIDTH = 32,
    parameter int CNT_WIDTH        = 16,
    parameter int CE_DIV_WIDTH     = 8
) (
    input  logic                               aclk,
    input  logic                               resetn,
    input  logic                               enable,
    input  logic        [CE_DIV_WIDTH-1:0]     ce_div,
    input  logic        [CNT_WIDTH-1:0]        period,
    input  logic        [CNT_WIDTH-1:0]        duty,
    input  logic signed [MODEL_DATA_WIDTH-1:0] iL,
    input  logic signed [MODEL_DATA_WIDTH-1:0] ilim,
    output logic                               ce,
    output logic                               s1,
    output logic                               period_start,
    output logic                               trip,
    output logic        [CNT_WIDTH-1:0]        cnt
);

    logic [CE_DIV_WIDTH-1:0] div_cnt;
    logic [CNT_WIDTH-1:0]    period_active;
    logic [CNT_WIDTH-1:0]    duty_active;
    logic                    first;

    logic                    div_wrap;
    logic                    step_start;
    logic [CNT_WIDTH-1:0]    step_n;
    logic [CNT_WIDTH-1:0]    duty_sel;
    logic                    over_current;
    logic                    trip_step;
    logic [CNT_WIDTH-1:0]    cnt_nxt;
    logic [CNT_WIDTH-1:0]    period_nxt;
    logic                    first_nxt;

    // Strict signed compare: iL equal to the limit is not an over-current.
    function automatic logic over_limit(
        input logic signed [MODEL_DATA_WIDTH-1:0] cur,
        input logic signed [MODEL_DATA_WIDTH-1:0] lim
    );
        return cur > lim;
    endfunction

    always_comb begin
        // '>=' rather than '==' so that lowering ce_div below the running
        // count wraps at once instead of running through the whole counter.
        div_wrap     = (div_cnt >= ce_div);

        step_start   = first || (cnt == period_active);
        step_n       = step_start ? '0 : cnt + 1'b1;
        // At a period start the freshly sampled duty applies immediately.
        duty_sel     = step_start ? duty : duty_active;
        over_current = over_limit(iL, ilim);
        // A period start wins over a same-step over-current.
        trip_step    = step_start ? 1'b0 : (trip | (s1 & over_current));

        // Carrier state as it will be after this edge. It is used to predict
        // whether the ce being raised now will start a period.
        cnt_nxt      = ce ? step_n : cnt;
        period_nxt   = (ce && step_start) ? period : period_active;
        first_nxt    = (ce && step_start) ? 1'b0 : first;
    end

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            div_cnt       <= '0;
            ce            <= 1'b0;
            s1            <= 1'b0;
            period_start  <= 1'b0;
            trip          <= 1'b0;
            cnt           <= '0;
            period_active <= '0;
            duty_active   <= '0;
            first         <= 1'b1;
        end else if (!enable) begin
            // Shadows are kept; the next enabled ce reloads them anyway.
            div_cnt      <= '0;
            ce           <= 1'b0;
            s1           <= 1'b0;
            period_start <= 1'b0;
            trip         <= 1'b0;
            cnt          <= '0;
            first        <= 1'b1;
        end else begin
            div_cnt      <= div_wrap ? '0 : div_cnt + 1'b1;
            ce           <= div_wrap;
            period_start <= div_wrap & (first_nxt | (cnt_nxt == period_nxt));

            if (ce) begin
                cnt  <= step_n;
                trip <= trip_step;
                s1   <= (step_n < duty_sel) & ~trip_step;
                if (step_start) begin
                    period_active <= period;
                    duty_active   <= duty;
                    first         <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_cbc_modulator.sv
// ---------------------------------------------------------------------------
// tb_pwm_cbc_modulator
//
// Directed testbench for pwm_cbc_modulator. It covers the prescaler, basic
// PWM, shadowed period/duty, duty and period bounds, and the cycle-by-cycle
// current limit. It also covers disable/re-enable and reset during operation.
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_pwm_cbc_modulator;

    logic               aclk;
    logic               resetn;
    logic               enable;
    logic        [7:0]  ce_div;
    logic        [15:0] period;
    logic        [15:0] duty;
    logic signed [31:0] iL;
    logic signed [31:0] ilim;
    logic               ce;
    logic               s1;
    logic               period_start;
    logic               trip;
    logic        [15:0] cnt;

    int n_vec = 0;
    int n_bad = 0;

    pwm_cbc_modulator #(
        .MODEL_DATA_WIDTH (32),
        .CNT_WIDTH        (16),
        .CE_DIV_WIDTH     (8)
    ) dut (
        .aclk         (aclk),
        .resetn       (resetn),
        .enable       (enable),
        .ce_div       (ce_div),
        .period       (period),
        .duty         (duty),
        .iL           (iL),
        .ilim         (ilim),
        .ce           (ce),
        .s1           (s1),
        .period_start (period_start),
        .trip         (trip),
        .cnt          (cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    // Disable for one cycle, load new period/duty, re-enable. On return the
    // first ce (t=1) is visible.
    task automatic restart(input logic [15:0] p, input logic [15:0] d);
        enable = 1'b0;
        tick();
        period = p;
        duty   = d;
        enable = 1'b1;
        tick();
    endtask

    initial begin
        int c;

        resetn = 1'b0;
        enable = 1'b0;
        ce_div = 8'd0;
        period = 16'd9;
        duty   = 16'd3;
        iL     = 32'sd0;
        ilim   = 32'sh0100_0000;
        tick();
        tick();

        // Reset state
        check_vec("rst_ce",    ce,           1'b0);
        check_vec("rst_s1",    s1,           1'b0);
        check_vec("rst_ps",    period_start, 1'b0);
        check_vec("rst_trip",  trip,         1'b0);
        check_vec("rst_cnt",   cnt,          16'd0);

        // Prescaler, ce_div=3: ce high on every 4th cycle
        resetn = 1'b1;
        ce_div = 8'd3;
        enable = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            check_vec($sformatf("ce_div3 t=%0d", t), ce, (t % 4 == 0));
        end

        // Disabled: ce stays low
        enable = 1'b0;
        for (int t = 1; t <= 6; t++) begin
            tick();
            check_vec($sformatf("ce_off t=%0d", t), ce, 1'b0);
        end

        // ce_div=0: ce every cycle
        ce_div = 8'd0;
        enable = 1'b1;
        for (int t = 1; t <= 5; t++) begin
            tick();
            check_vec($sformatf("ce_div0 t=%0d", t), ce, 1'b1);
        end

        // Basic PWM: period=9, duty=3
        restart(16'd9, 16'd3);
        check_vec("pwm t=1 ps",  period_start, 1'b1);
        check_vec("pwm t=1 cnt", cnt,          16'd0);
        check_vec("pwm t=1 s1",  s1,           1'b0);
        for (int t = 2; t <= 31; t++) begin
            tick();
            c = (t - 2) % 10;
            check_vec($sformatf("pwm cnt t=%0d", t), cnt,          16'(c));
            check_vec($sformatf("pwm s1 t=%0d", t),  s1,           (c < 3));
            check_vec($sformatf("pwm ps t=%0d", t),  period_start, (c == 9));
        end

        // Shadowing: duty 3->7 at cnt=5, then period 9->4 at cnt=5 next period
        restart(16'd9, 16'd3);
        for (int t = 2; t <= 27; t++) begin
            tick();
            c = (t <= 21) ? (t - 2) % 10 : (t - 22) % 5;
            check_vec($sformatf("shd cnt t=%0d", t), cnt, 16'(c));
            if (t <= 11)
                check_vec($sformatf("shd s1 t=%0d", t), s1, (c < 3));
            else if (t <= 21)
                check_vec($sformatf("shd s1 t=%0d", t), s1, (c < 7));
            else
                check_vec($sformatf("shd s1 t=%0d", t), s1, 1'b1);
            check_vec($sformatf("shd ps t=%0d", t), period_start, (t <= 21) ? (c == 9) : (c == 4));
            if (t == 7)  duty   = 16'd7;
            if (t == 17) period = 16'd4;
        end

        // duty=0: s1 never high
        restart(16'd9, 16'd0);
        for (int t = 2; t <= 13; t++) begin
            tick();
            check_vec($sformatf("d0 s1 t=%0d", t), s1, 1'b0);
        end

        // duty > period: s1 constant 1, period_start still every 10
        restart(16'd9, 16'd10);
        for (int t = 2; t <= 21; t++) begin
            tick();
            c = (t - 2) % 10;
            check_vec($sformatf("d100 s1 t=%0d", t), s1,           1'b1);
            check_vec($sformatf("d100 ps t=%0d", t), period_start, (c == 9));
        end

        // period=0, duty=1: every ce starts a period
        restart(16'd0, 16'd1);
        check_vec("p0 t=1 ps", period_start, 1'b1);
        for (int t = 2; t <= 6; t++) begin
            tick();
            check_vec($sformatf("p0 ps t=%0d", t),  period_start, 1'b1);
            check_vec($sformatf("p0 s1 t=%0d", t),  s1,           1'b1);
            check_vec($sformatf("p0 cnt t=%0d", t), cnt,          16'd0);
        end

        // Current limit: period=9, duty=6, over-current at cnt=2
        restart(16'd9, 16'd6);
        for (int t = 2; t <= 4; t++) begin
            tick();
            check_vec($sformatf("oc pre s1 t=%0d", t), s1, 1'b1);
        end
        iL = ilim + 32'sd1;                       // cnt=2 now
        for (int t = 5; t <= 11; t++) begin
            tick();
            check_vec($sformatf("oc trip t=%0d", t), trip, 1'b1);
            check_vec($sformatf("oc s1 t=%0d", t),   s1,   1'b0);
            if (t == 8)  iL = 32'sd0;
            if (t == 11) iL = ilim + 32'sd1;      // over-current lands on the period start
        end
        tick();                                   // t=12: period start wins
        check_vec("oc start cnt",  cnt,  16'd0);
        check_vec("oc start trip", trip, 1'b0);
        check_vec("oc start s1",   s1,   1'b1);
        tick();                                   // t=13: persisting over-current re-trips
        check_vec("oc retrip trip", trip, 1'b1);
        check_vec("oc retrip s1",   s1,   1'b0);
        iL = 32'sd0;
        tick();                                   // t=14: latch holds
        check_vec("oc hold trip", trip, 1'b1);
        check_vec("oc hold s1",   s1,   1'b0);

        // iL equal to ilim: no trip
        iL = ilim;
        restart(16'd9, 16'd6);
        for (int t = 2; t <= 13; t++) begin
            tick();
            c = (t - 2) % 10;
            check_vec($sformatf("eq trip t=%0d", t), trip, 1'b0);
            check_vec($sformatf("eq s1 t=%0d", t),   s1,   (c < 6));
        end

        // Negative iL with positive ilim: no trip
        iL = -32'sd33554432;
        restart(16'd9, 16'd6);
        for (int t = 2; t <= 13; t++) begin
            tick();
            c = (t - 2) % 10;
            check_vec($sformatf("neg trip t=%0d", t), trip, 1'b0);
            check_vec($sformatf("neg s1 t=%0d", t),   s1,   (c < 6));
        end
        iL = 32'sd0;

        // Disable at cnt=4 with s1=1, then re-enable
        restart(16'd9, 16'd6);
        for (int t = 2; t <= 6; t++) tick();
        check_vec("dis pre cnt", cnt, 16'd4);
        check_vec("dis pre s1",  s1,  1'b1);
        enable = 1'b0;
        tick();
        check_vec("dis s1",   s1,           1'b0);
        check_vec("dis ce",   ce,           1'b0);
        check_vec("dis cnt",  cnt,          16'd0);
        check_vec("dis ps",   period_start, 1'b0);
        check_vec("dis trip", trip,         1'b0);
        enable = 1'b1;
        tick();
        check_vec("reen ce",  ce,           1'b1);
        check_vec("reen ps",  period_start, 1'b1);
        check_vec("reen cnt", cnt,          16'd0);
        tick();
        tick();
        tick();
        check_vec("mid cnt", cnt, 16'd2);
        check_vec("mid s1",  s1,  1'b1);

        // Reset mid-period
        resetn = 1'b0;
        tick();
        check_vec("mrst ce",   ce,           1'b0);
        check_vec("mrst s1",   s1,           1'b0);
        check_vec("mrst ps",   period_start, 1'b0);
        check_vec("mrst trip", trip,         1'b0);
        check_vec("mrst cnt",  cnt,          16'd0);
        resetn = 1'b1;
        tick();
        check_vec("post rst ps",  period_start, 1'b1);
        check_vec("post rst cnt", cnt,          16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
